up_cu_ext: RTL and testbench

UP_CU_EXT -- requirements
Module: up_cu_ext

---
 rtl/up_cu_pkg.sv | 71 +++++++
 rtl/up_cu_ext_if.sv | 36 +++
 rtl/up_cu_waitctr.sv | 22 ++
 rtl/up_cu_ext.sv | 146 ++++++++++++++
 tb/tb_up_cu_ext.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/up_cu_pkg.sv
// Shared encodings for the up_cu_ext control unit: FSM states, opcodes,
// A-source and ALU function codes, plus the small decode helpers.
package up_cu_pkg;

  typedef enum logic [3:0] {
    S_START   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_LOAD    = 4'd3,
    S_STORE   = 4'd4,
    S_ALU     = 4'd5,
    S_IN_WAIT = 4'd6,
    S_IN_REL  = 4'd7,
    S_JUMP    = 4'd8,
    S_OUTP    = 4'd9,
    S_HALT    = 4'd10,
    S_CALL    = 4'd11,
    S_RET     = 4'd12
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_IN    = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_JPOS  = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd7;
  localparam logic [3:0] OP_JMP   = 4'd8;
  localparam logic [3:0] OP_JNZ   = 4'd9;
  localparam logic [3:0] OP_OUT   = 4'd10;
  localparam logic [3:0] OP_AND   = 4'd11;
  localparam logic [3:0] OP_OR    = 4'd12;
  localparam logic [3:0] OP_NOP   = 4'd13;
  localparam logic [3:0] OP_CALL  = 4'd14;
  localparam logic [3:0] OP_RET   = 4'd15;

  typedef enum logic [1:0] {
    ASEL_ALU = 2'b00,
    ASEL_IN  = 2'b01,
    ASEL_MEM = 2'b10
  } asel_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_t;

  function automatic alu_t alu_of(logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Non-jump opcodes routed through JUMP (NOP and friends) fall to "not taken".
  function automatic logic jump_taken(logic [3:0] op, logic aeq0, logic apos);
    case (op)
      OP_JZ:   return aeq0;
      OP_JPOS: return apos;
      OP_JMP:  return 1'b1;
      OP_JNZ:  return !aeq0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/up_cu_ext_if.sv
// Datapath <-> control-unit signal bundle. The datapath side is the master
// (drives IR, flags and Enter); the control unit is the slave.
interface up_cu_ext_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] IR;
  logic           Aeq0;
  logic           Apos;
  logic           Enter;
  logic           IRload;
  logic           PCload;
  logic           JMPmux;
  logic           Meminst;
  logic           MemWr;
  logic           Aload;
  logic           Halt;
  logic           Out;
  logic [1:0]     Asel;
  logic [1:0]     ALUop;
  logic           Sub;
  logic           PushPC;
  logic           PopPC;
  logic [3:0]     outState;

  modport master (
    output IR, Aeq0, Apos, Enter,
    input  IRload, PCload, JMPmux, Meminst, MemWr, Aload, Halt, Out,
           Asel, ALUop, Sub, PushPC, PopPC, outState
  );

  modport slave (
    input  IR, Aeq0, Apos, Enter,
    output IRload, PCload, JMPmux, Meminst, MemWr, Aload, Halt, Out,
           Asel, ALUop, Sub, PushPC, PopPC, outState
  );
endinterface

// File: rtl/up_cu_waitctr.sv
// Memory wait counter: counts cycles spent in a memory state; done flags the
// final cycle (count == MEM_WAIT). Synchronous active-high reset.
module up_cu_waitctr #(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);
  logic [2:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= 3'd0;
    else if (enable)  cnt <= cnt + 3'd1;
  end

  assign done = (cnt == 3'(MEM_WAIT));
endmodule

// File: rtl/up_cu_ext.sv
// up_cu_ext: multi-cycle control unit FSM with memory wait states.
// Define UP_CU_EXT_CALL_EN to enable CALL (opcode 14) and RET (opcode 15).
module up_cu_ext
  import up_cu_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int MEM_WAIT = 0
) (
  input logic        CLOCK,
  input logic        RESET,
  up_cu_ext_if.slave bus
);
  state_t state, state_nx;
  logic [3:0] op;
  logic       in_mem, wait_done, wait_clear;
  logic       irload, pcload, jmpmux, meminst, memwr, aload, halt, outp;
  logic       push_pc, pop_pc;
  asel_t      asel;
  alu_t       aluop;

  // With OPW=3 the upper opcode bit is zero, so opcodes 8..15 never decode.
  assign op = 4'(bus.IR[OPW-1:0]);

  assign in_mem     = (state == S_FETCH) || (state == S_LOAD) || (state == S_STORE);
  assign wait_clear = !in_mem || wait_done;

  up_cu_waitctr #(.MEM_WAIT(MEM_WAIT)) u_waitctr (
    .clk    (CLOCK),
    .rst    (RESET),
    .clear  (wait_clear),
    .enable (in_mem),
    .done   (wait_done)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= S_START;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    irload   = 1'b0;
    pcload   = 1'b0;
    jmpmux   = 1'b0;
    meminst  = 1'b0;
    memwr    = 1'b0;
    aload    = 1'b0;
    halt     = 1'b0;
    outp     = 1'b0;
    push_pc  = 1'b0;
    pop_pc   = 1'b0;
    asel     = ASEL_ALU;
    aluop    = ALU_ADD;
    case (state)
      S_START: state_nx = S_FETCH;
      S_FETCH: if (wait_done) begin
        irload   = 1'b1;
        pcload   = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        meminst = 1'b1;
        case (op)
          OP_LOAD:                        state_nx = S_LOAD;
          OP_STORE:                       state_nx = S_STORE;
          OP_ADD, OP_SUB, OP_AND, OP_OR:  state_nx = S_ALU;
          OP_IN:                          state_nx = S_IN_WAIT;
          OP_HALT:                        state_nx = S_HALT;
          OP_OUT:                         state_nx = S_OUTP;
`ifdef UP_CU_EXT_CALL_EN
          OP_CALL:                        state_nx = S_CALL;
          OP_RET:                         state_nx = S_RET;
`endif
          default:                        state_nx = S_JUMP;
        endcase
      end
      S_LOAD: begin
        meminst = 1'b1;
        asel    = ASEL_MEM;
        if (wait_done) begin
          aload    = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_STORE: begin
        meminst = 1'b1;
        memwr   = 1'b1;
        if (wait_done) state_nx = S_FETCH;
      end
      S_ALU: begin
        aload    = 1'b1;
        aluop    = alu_of(op);
        state_nx = S_FETCH;
      end
      S_IN_WAIT: if (bus.Enter) begin
        asel     = ASEL_IN;
        aload    = 1'b1;
        state_nx = S_IN_REL;
      end
      S_IN_REL: if (!bus.Enter) state_nx = S_FETCH;
      S_JUMP: begin
        if (jump_taken(op, bus.Aeq0, bus.Apos)) begin
          jmpmux = 1'b1;
          pcload = 1'b1;
        end
        state_nx = S_FETCH;
      end
      S_OUTP: begin
        outp     = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT: halt = 1'b1;
`ifdef UP_CU_EXT_CALL_EN
      S_CALL: begin
        push_pc  = 1'b1;
        jmpmux   = 1'b1;
        pcload   = 1'b1;
        state_nx = S_FETCH;
      end
      S_RET: begin
        pop_pc   = 1'b1;
        pcload   = 1'b1;
        state_nx = S_FETCH;
      end
`endif
      default: state_nx = S_START;
    endcase
  end

  assign bus.IRload   = irload;
  assign bus.PCload   = pcload;
  assign bus.JMPmux   = jmpmux;
  assign bus.Meminst  = meminst;
  assign bus.MemWr    = memwr;
  assign bus.Aload    = aload;
  assign bus.Halt     = halt;
  assign bus.Out      = outp;
  assign bus.Asel     = asel;
  assign bus.ALUop    = aluop;
  assign bus.Sub      = aload && (aluop == ALU_SUB);
  assign bus.PushPC   = push_pc;
  assign bus.PopPC    = pop_pc;
  assign bus.outState = state;
endmodule

// File: tb/tb_up_cu_ext.sv
// Self-checking bench for up_cu_ext: three instances (MEM_WAIT 0, 2, 3),
// a per-opcode vector table, directed corner sequences and a random program.
module tb_up_cu_ext;

  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;
  logic RESET = 1'b0;

  up_cu_ext_if #(.OPW(4)) b0 ();
  up_cu_ext_if #(.OPW(4)) b2 ();
  up_cu_ext_if #(.OPW(4)) b3 ();

  up_cu_ext #(.OPW(4), .MEM_WAIT(0)) u0 (.CLOCK(CLOCK), .RESET(RESET), .bus(b0));
  up_cu_ext #(.OPW(4), .MEM_WAIT(2)) u2 (.CLOCK(CLOCK), .RESET(RESET), .bus(b2));
  up_cu_ext #(.OPW(4), .MEM_WAIT(3)) u3 (.CLOCK(CLOCK), .RESET(RESET), .bus(b3));

  typedef struct packed {
    logic [3:0] st;
    logic       irload, pcload, jmpmux, meminst, memwr, aload, halt, outp;
    logic [1:0] asel, aluop;
    logic       sub, push, pop;
  } outs_t;

  typedef struct {
    logic [3:0] op;
    logic       aeq0, apos;
    outs_t      exp;
  } vec_t;

  logic [3:0] ir_v    [3];
  logic       aeq0_v  [3];
  logic       apos_v  [3];
  logic       enter_v [3];

  assign b0.IR = ir_v[0]; assign b0.Aeq0 = aeq0_v[0]; assign b0.Apos = apos_v[0]; assign b0.Enter = enter_v[0];
  assign b2.IR = ir_v[1]; assign b2.Aeq0 = aeq0_v[1]; assign b2.Apos = apos_v[1]; assign b2.Enter = enter_v[1];
  assign b3.IR = ir_v[2]; assign b3.Aeq0 = aeq0_v[2]; assign b3.Apos = apos_v[2]; assign b3.Enter = enter_v[2];

  outs_t act0, act1, act2;
  assign act0 = {b0.outState, b0.IRload, b0.PCload, b0.JMPmux, b0.Meminst, b0.MemWr, b0.Aload,
                 b0.Halt, b0.Out, b0.Asel, b0.ALUop, b0.Sub, b0.PushPC, b0.PopPC};
  assign act1 = {b2.outState, b2.IRload, b2.PCload, b2.JMPmux, b2.Meminst, b2.MemWr, b2.Aload,
                 b2.Halt, b2.Out, b2.Asel, b2.ALUop, b2.Sub, b2.PushPC, b2.PopPC};
  assign act2 = {b3.outState, b3.IRload, b3.PCload, b3.JMPmux, b3.Meminst, b3.MemWr, b3.Aload,
                 b3.Halt, b3.Out, b3.Asel, b3.ALUop, b3.Sub, b3.PushPC, b3.PopPC};

  int checks = 0;
  int errors = 0;

  function automatic outs_t get_act(int k);
    case (k)
      0:       return act0;
      1:       return act1;
      default: return act2;
    endcase
  endfunction

  function automatic outs_t st_only(int s);
    outs_t r = '0;
    r.st = 4'(s);
    return r;
  endfunction

  function automatic vec_t v(int op, int z, int p, int st, int jm, int pc, int ld,
                             int alu, int sb, int ou, int ps, int pp);
    vec_t r;
    r.op         = 4'(op);
    r.aeq0       = (z != 0);
    r.apos       = (p != 0);
    r.exp        = st_only(st);
    r.exp.jmpmux = (jm != 0);
    r.exp.pcload = (pc != 0);
    r.exp.aload  = (ld != 0);
    r.exp.aluop  = 2'(alu);
    r.exp.sub    = (sb != 0);
    r.exp.outp   = (ou != 0);
    r.exp.push   = (ps != 0);
    r.exp.pop    = (pp != 0);
    return r;
  endfunction

  // Reference for the single execute cycle of an instruction, from the opcode
  // meaning: ALU ops load A, jumps load PC when their condition holds, etc.
  function automatic outs_t exec_model(logic [3:0] op, logic z, logic p);
    outs_t r = '0;
    logic  taken;
    case (op)
      4'd2, 4'd3, 4'd11, 4'd12: begin
        r.st    = 4'd5;
        r.aload = 1'b1;
        r.aluop = (op == 4'd3) ? 2'd1 : (op == 4'd11) ? 2'd2 : (op == 4'd12) ? 2'd3 : 2'd0;
        r.sub   = (op == 4'd3);
      end
      4'd10: begin
        r.st   = 4'd9;
        r.outp = 1'b1;
      end
`ifdef UP_CU_EXT_CALL_EN
      4'd14: begin
        r.st = 4'd11; r.push = 1'b1; r.jmpmux = 1'b1; r.pcload = 1'b1;
      end
      4'd15: begin
        r.st = 4'd12; r.pop = 1'b1; r.pcload = 1'b1;
      end
`endif
      default: begin
        taken    = (op == 4'd5 && z) || (op == 4'd6 && p) || (op == 4'd8) || (op == 4'd9 && !z);
        r.st     = 4'd8;
        r.jmpmux = taken;
        r.pcload = taken;
      end
    endcase
    return r;
  endfunction

  task automatic chk(int k, outs_t e, string name);
    outs_t a = get_act(k);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: dut%0d outputs %h, expected %h", name, k, a, e);
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance past the rising edge.
  task automatic cyc(int k, outs_t e, string name);
    @(negedge CLOCK);
    chk(k, e, name);
    @(posedge CLOCK);
    #1;
  endtask

  task automatic rand_inputs(int k);
    aeq0_v[k]  = 1'($urandom);
    apos_v[k]  = 1'($urandom);
    enter_v[k] = 1'($urandom);
  endtask

  task automatic fetch_decode(int k, int mw, logic [3:0] op);
    outs_t e;
    ir_v[k] = op;
    for (int i = 0; i <= mw; i++) begin
      e = st_only(1);
      if (i == mw) begin
        e.irload = 1'b1;
        e.pcload = 1'b1;
      end
      cyc(k, e, "fetch");
    end
    e = st_only(2);
    e.meminst = 1'b1;
    cyc(k, e, "decode");
  endtask

  task automatic run_instr(int k, int mw, logic [3:0] op, bit rnd);
    outs_t e;
    fetch_decode(k, mw, op);
    if (op == 4'd0) begin
      for (int i = 0; i <= mw; i++) begin
        if (rnd) rand_inputs(k);
        e = st_only(3); e.meminst = 1'b1; e.asel = 2'b10; e.aload = (i == mw);
        cyc(k, e, "load");
      end
    end else if (op == 4'd1) begin
      for (int i = 0; i <= mw; i++) begin
        if (rnd) rand_inputs(k);
        e = st_only(4); e.meminst = 1'b1; e.memwr = 1'b1;
        cyc(k, e, "store");
      end
    end else begin
      if (rnd) rand_inputs(k);
      cyc(k, exec_model(op, aeq0_v[k], apos_v[k]), "exec");
    end
  endtask

  vec_t tbl [15];

  initial begin
    outs_t      e;
    logic [3:0] op;

    tbl[0]  = v( 2, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = v( 3, 1, 0, 5, 0, 0, 1, 1, 1, 0, 0, 0);
    tbl[2]  = v(11, 0, 1, 5, 0, 0, 1, 2, 0, 0, 0, 0);
    tbl[3]  = v(12, 1, 1, 5, 0, 0, 1, 3, 0, 0, 0, 0);
    tbl[4]  = v( 5, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = v( 5, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = v( 6, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = v( 6, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = v( 8, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = v( 9, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = v( 9, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = v(10, 0, 0, 9, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[12] = v(13, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef UP_CU_EXT_CALL_EN
    tbl[13] = v(14, 1, 0, 11, 1, 1, 0, 0, 0, 0, 1, 0);
    tbl[14] = v(15, 0, 1, 12, 0, 1, 0, 0, 0, 0, 0, 1);
`else
    tbl[13] = v(14, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = v(15, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    for (int k = 0; k < 3; k++) begin
      ir_v[k] = 4'd0; aeq0_v[k] = 1'b0; apos_v[k] = 1'b0; enter_v[k] = 1'b0;
    end

    // Reset: every instance shows START with all strobes low.
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    @(negedge CLOCK);
    for (int k = 0; k < 3; k++) chk(k, st_only(0), "reset_start");
    @(posedge CLOCK); #1;

    // Opcode table on MEM_WAIT=0; the first entry (ADD) gives 0,1,2,5,1.
    for (int i = 0; i < 15; i++) begin
      aeq0_v[0] = tbl[i].aeq0;
      apos_v[0] = tbl[i].apos;
      fetch_decode(0, 0, tbl[i].op);
      cyc(0, tbl[i].exp, $sformatf("table%0d_op%0d", i, tbl[i].op));
    end

    // Input handshake: 5 idle cycles, 4 high, then release; one load only.
    enter_v[0] = 1'b0;
    fetch_decode(0, 0, 4'd4);
    repeat (5) cyc(0, st_only(6), "in_wait_idle");
    enter_v[0] = 1'b1;
    e = st_only(6); e.asel = 2'b01; e.aload = 1'b1;
    cyc(0, e, "in_press");
    repeat (3) cyc(0, st_only(7), "in_hold");
    enter_v[0] = 1'b0;
    cyc(0, st_only(7), "in_release");

    // HALT holds for 20 cycles whatever the inputs do, then reset escapes it.
    fetch_decode(0, 0, 4'd7);
    e = st_only(10); e.halt = 1'b1;
    repeat (20) begin
      rand_inputs(0);
      ir_v[0] = 4'($urandom);
      cyc(0, e, "halt_hold");
    end
    RESET = 1'b1;
    enter_v[0] = 1'b1;
    cyc(0, e, "halt_until_edge");
    RESET = 1'b0;
    enter_v[0] = 1'b0;
    cyc(0, st_only(0), "reset_from_halt");

    // MEM_WAIT=2 LOAD: three fetch cycles, three load cycles, strobes in the last.
    for (int k = 0; k < 3; k++) begin
      aeq0_v[k] = 1'b0; apos_v[k] = 1'b0; enter_v[k] = 1'b0;
    end
    run_instr(1, 2, 4'd0, 1'b0);

    // Random program on MEM_WAIT=2 (no input or halt opcodes).
    repeat (40) begin
      do op = 4'($urandom_range(0, 15)); while (op == 4'd4 || op == 4'd7);
      run_instr(1, 2, op, 1'b1);
    end
    enter_v[1] = 1'b0;

    // Reset during the second cycle of a MEM_WAIT=3 STORE.
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    cyc(2, st_only(0), "u3_start");
    fetch_decode(2, 3, 4'd1);
    e = st_only(4); e.meminst = 1'b1; e.memwr = 1'b1;
    cyc(2, e, "store_c1");
    RESET = 1'b1;
    cyc(2, e, "store_c2");
    RESET = 1'b0;
    cyc(2, st_only(0), "store_reset");
    run_instr(2, 3, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
